// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, hazard stall codes, FSM states.
package ex_muldiv_unit_pkg;

    localparam int unsigned MD_OP_WIDTH = 3;

    // Op codes follow the RV32M funct3 encoding
    localparam logic [MD_OP_WIDTH-1:0] MD_MUL    = 3'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_MULH   = 3'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_MULHSU = 3'd2;
    localparam logic [MD_OP_WIDTH-1:0] MD_MULHU  = 3'd3;
    localparam logic [MD_OP_WIDTH-1:0] MD_DIV    = 3'd4;
    localparam logic [MD_OP_WIDTH-1:0] MD_DIVU   = 3'd5;
    localparam logic [MD_OP_WIDTH-1:0] MD_REM    = 3'd6;
    localparam logic [MD_OP_WIDTH-1:0] MD_REMU   = 3'd7;

    localparam int unsigned STALL_WIDTH = 2;
    localparam logic [STALL_WIDTH-1:0] STALL_NONE   = 2'd0;
    localparam logic [STALL_WIDTH-1:0] STALL_LOAD   = 2'd1;
    localparam logic [STALL_WIDTH-1:0] STALL_BRANCH = 2'd2;
    localparam logic [STALL_WIDTH-1:0] STALL_MULDIV = 2'd3;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/ex_muldiv_unit_div_core.sv
// One restoring-divide step on unsigned magnitudes; relies on rem < divisor between steps.
module ex_div_core #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quot,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quot
);

    logic [W:0] w_shift;
    logic [W:0] w_diff;

    // With rem < divisor the top bit of the difference is exactly the borrow
    assign w_shift = {i_rem, i_quot[W-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_rem   = w_diff[W] ? w_shift[W-1:0] : w_diff[W-1:0];
    assign o_quot  = {i_quot[W-2:0], ~w_diff[W]};

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M multiply/divide unit: 32-step shift-add multiply / restoring divide with stall request.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   md_start_ex,
    input  logic [MD_OP_WIDTH-1:0] md_op_ex,
    input  logic [XLEN-1:0]        op_a,
    input  logic [XLEN-1:0]        op_b,
    input  logic                   flush,
    output logic [XLEN-1:0]        md_result,
    output logic                   md_done,
    output logic                   md_busy,
    output logic                   md_stall_req
);

    localparam int unsigned CNT_W = $clog2(ITER) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [MD_OP_WIDTH-1:0] r_op;
    logic                   r_neg_res;
    logic                   r_neg_rem;
    logic [XLEN-1:0]        r_mag_a;
    logic [XLEN-1:0]        r_mag_b;
    logic [XLEN-1:0]        r_rem;
    logic [XLEN-1:0]        r_quot;
    logic [2*XLEN-1:0]      r_acc;
    logic [XLEN-1:0]        r_result;
    logic                   r_done;
    logic                   r_busy;

    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic              w_div_zero;
    logic              w_overflow;
    logic              w_special;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quot_nxt;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_final;

    // Operand decode for the op presented in EX
    assign w_is_div   = md_op_ex[2];
    assign w_a_signed = (md_op_ex == MD_MULH) || (md_op_ex == MD_MULHSU) ||
                        (md_op_ex == MD_DIV)  || (md_op_ex == MD_REM);
    assign w_b_signed = (md_op_ex == MD_MULH) || (md_op_ex == MD_DIV) || (md_op_ex == MD_REM);
    assign w_sa       = w_a_signed & op_a[XLEN-1];
    assign w_sb       = w_b_signed & op_b[XLEN-1];
    assign w_abs_a    = w_sa ? -op_a : op_a;
    assign w_abs_b    = w_sb ? -op_b : op_b;
    assign w_div_zero = w_is_div & (op_b == '0);
    assign w_overflow = w_is_div & w_a_signed & w_b_signed & (op_a == MIN_NEG) & (&op_b);
    assign w_special  = w_div_zero | w_overflow;

    // Divide-by-zero and signed overflow resolve without iterating
    always_comb begin
        w_special_res = op_a;
        if (w_div_zero && !md_op_ex[1]) begin
            w_special_res = '1;
        end else if (w_overflow && md_op_ex[1]) begin
            w_special_res = '0;
        end
    end

    // Multiply step: conditional add into the upper half, then shift right
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_mag_a & {XLEN{r_acc[0]}}};
    assign w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};

    ex_div_core #(
        .W(XLEN)
    ) u_div_core (
        .i_rem    (r_rem),
        .i_quot   (r_quot),
        .i_divisor(r_mag_b),
        .o_rem    (w_rem_nxt),
        .o_quot   (w_quot_nxt)
    );

    // Sign fix on the final-iteration values
    assign w_prod     = r_neg_res ? -w_acc_nxt : w_acc_nxt;
    assign w_quot_fix = r_neg_res ? -w_quot_nxt : w_quot_nxt;
    assign w_rem_fix  = r_neg_rem ? -w_rem_nxt : w_rem_nxt;

    always_comb begin
        w_final = w_rem_fix;
        case (r_op)
            MD_MUL:                       w_final = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              w_final = w_quot_fix;
            default:                      w_final = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (md_start_ex && !flush) begin
                        r_op      <= md_op_ex;
                        r_neg_res <= w_sa ^ w_sb;
                        r_neg_rem <= w_sa;
                        r_mag_a   <= w_abs_a;
                        r_mag_b   <= w_abs_b;
                        r_acc     <= {XLEN'(0), w_abs_b};
                        r_rem     <= '0;
                        r_quot    <= w_abs_a;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= MD_DONE;
                        end else begin
                            r_state  <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (flush) begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc  <= w_acc_nxt;
                        r_rem  <= w_rem_nxt;
                        r_quot <= w_quot_nxt;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(ITER - 1)) begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_state  <= MD_DONE;
                        end
                    end
                end
                MD_DONE: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stall drops on the done cycle and as soon as a flush is seen
    assign md_stall_req = rst & ~flush &
                          (((r_state == MD_IDLE) & md_start_ex) | (r_state == MD_CALC));

    assign md_result = r_result;
    assign md_done   = r_done;
    assign md_busy   = r_busy;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        md_start_ex = 1'b0;
    logic [2:0]  md_op_ex = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] md_result;
    logic        md_done;
    logic        md_busy;
    logic        md_stall_req;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    ex_muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .md_start_ex (md_start_ex),
        .md_op_ex    (md_op_ex),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .md_result   (md_result),
        .md_done     (md_done),
        .md_busy     (md_busy),
        .md_stall_req(md_stall_req)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents an op and waits for md_done, measuring latency and stall cycles
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int stalls,
                         output logic done_stall, output bit tmo);
        @(negedge clk);
        md_op_ex = op; op_a = a; op_b = b; md_start_ex = 1'b1;
        #1;
        lat = 0; stalls = 0; tmo = 1'b0;
        while (md_done !== 1'b1 && !tmo) begin
            if (md_stall_req === 1'b1) stalls++;
            @(negedge clk); #1;
            lat++;
            if (lat > 60) tmo = 1'b1;
        end
        res = md_result;
        done_stall = md_stall_req;
    endtask

    task automatic test_reset();
        md_start_ex = 1'b1; md_op_ex = MD_MUL; op_a = 32'd3; op_b = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (md_result !== 32'd0 || md_done !== 1'b0 || md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: result=%h done=%b busy=%b required 0/0/0", md_result, md_done, md_busy);
        end
        n_tests++;
        if (md_stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: stall=%b required 0", md_stall_req);
        end
        @(negedge clk);
        md_start_ex = 1'b0; rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith();
        vec_t v [12];
        logic [31:0] res;
        int lat, stalls;
        logic dstall;
        bit tmo;
        v[0]  = '{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        v[1]  = '{MD_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF};
        v[2]  = '{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[3]  = '{MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        v[4]  = '{MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        v[5]  = '{MD_MULHSU, 32'd3,          32'hFFFF_FFFF, 32'h0000_0002};
        v[6]  = '{MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        v[7]  = '{MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        v[8]  = '{MD_DIVU,   32'd100,        32'd7,         32'd14};
        v[9]  = '{MD_REMU,   32'd100,        32'd7,         32'd2};
        v[10] = '{MD_REM,    32'd7,          32'hFFFF_FFFE, 32'd1};
        v[11] = '{MD_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 12; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, res, lat, stalls, dstall, tmo);
            n_tests++;
            if (tmo) begin
                n_fail++;
                $display("FAIL arith[%0d] timeout: no md_done within 60 cycles", i);
            end else begin
                n_tests++;
                if (res !== v[i].exp) begin
                    n_fail++;
                    $display("FAIL arith[%0d] result op=%0d: got %h required %h", i, v[i].op, res, v[i].exp);
                end
                n_tests++;
                if (lat != 33 || stalls != 33 || dstall !== 1'b0) begin
                    n_fail++;
                    $display("FAIL arith[%0d] timing: lat=%0d stalls=%0d done_stall=%b required 33/33/0", i, lat, stalls, dstall);
                end
            end
            @(negedge clk);
            md_start_ex = 1'b0;
            #1;
            n_tests++;
            if (md_done !== 1'b0 || md_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL arith[%0d] done_pulse: done=%b busy=%b required 0/0 after done", i, md_done, md_busy);
            end
        end
    endtask

    task automatic test_special();
        vec_t v [6];
        logic [31:0] res;
        int lat, stalls;
        logic dstall;
        bit tmo;
        v[0] = '{MD_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF};
        v[1] = '{MD_REM,  32'd5,         32'd0,         32'd5};
        v[2] = '{MD_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF};
        v[3] = '{MD_REMU, 32'd9,         32'd0,         32'd9};
        v[4] = '{MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[5] = '{MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 6; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, res, lat, stalls, dstall, tmo);
            n_tests++;
            if (tmo) begin
                n_fail++;
                $display("FAIL special[%0d] timeout: no md_done within 60 cycles", i);
            end else begin
                n_tests++;
                if (res !== v[i].exp) begin
                    n_fail++;
                    $display("FAIL special[%0d] result op=%0d: got %h required %h", i, v[i].op, res, v[i].exp);
                end
                n_tests++;
                if (lat != 1 || stalls != 1 || dstall !== 1'b0) begin
                    n_fail++;
                    $display("FAIL special[%0d] timing: lat=%0d stalls=%0d done_stall=%b required 1/1/0", i, lat, stalls, dstall);
                end
            end
            @(negedge clk);
            md_start_ex = 1'b0;
            #1;
            n_tests++;
            if (md_done !== 1'b0 || md_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL special[%0d] done_pulse: done=%b busy=%b required 0/0 after done", i, md_done, md_busy);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, stalls;
        logic dstall;
        bit tmo;
        bit seen_done;
        @(negedge clk);
        md_op_ex = MD_DIVU; op_a = 32'd100; op_b = 32'd7; md_start_ex = 1'b1; flush = 1'b1;
        #1;
        n_tests++;
        if (md_stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_stall: stall=%b required 0", md_stall_req);
        end
        @(negedge clk);
        md_start_ex = 1'b0; flush = 1'b0;
        #1;
        n_tests++;
        if (md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_nostart: busy=%b required 0", md_busy);
        end
        @(negedge clk);
        md_start_ex = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        n_tests++;
        if (md_stall_req !== 1'b0 || md_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_calc_stall: stall=%b busy=%b required 0/1", md_stall_req, md_busy);
        end
        @(negedge clk);
        flush = 1'b0; md_start_ex = 1'b0;
        #1;
        n_tests++;
        if (md_busy !== 1'b0 || md_stall_req !== 1'b0 || md_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_calc_abort: busy=%b stall=%b done=%b required 0/0/0", md_busy, md_stall_req, md_done);
        end
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (md_done === 1'b1) seen_done = 1'b1;
        end
        n_tests++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL flush_no_done: md_done seen=1 required 0");
        end
        do_op(MD_MUL, 32'd3, 32'd4, res, lat, stalls, dstall, tmo);
        n_tests++;
        if (tmo || res !== 32'd12 || lat != 33) begin
            n_fail++;
            $display("FAIL flush_then_mul: tmo=%b result=%h lat=%0d required 0/0000000c/33", tmo, res, lat);
        end
        @(negedge clk);
        md_start_ex = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        md_op_ex = MD_MUL; op_a = 32'd7; op_b = 32'd9; md_start_ex = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || md_result !== 32'd0 || md_stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b result=%h stall=%b required 0/0/0/0",
                     md_busy, md_done, md_result, md_stall_req);
        end
        @(negedge clk);
        rst = 1'b1; md_start_ex = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (md_busy !== 1'b0 || md_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_release: busy=%b done=%b required 0/0", md_busy, md_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res1, res2;
        int lat1, lat2, st1, st2, t1, t2;
        logic ds1, ds2;
        bit tmo1, tmo2;
        do_op(MD_MUL, 32'd2, 32'd3, res1, lat1, st1, ds1, tmo1);
        t1 = cyc;
        do_op(MD_MUL, 32'd4, 32'd5, res2, lat2, st2, ds2, tmo2);
        t2 = cyc;
        n_tests++;
        if (tmo1 || res1 !== 32'd6) begin
            n_fail++;
            $display("FAIL b2b_first: tmo=%b result=%h required 0/00000006", tmo1, res1);
        end
        n_tests++;
        if (tmo2 || res2 !== 32'd20 || lat2 != 33) begin
            n_fail++;
            $display("FAIL b2b_second: tmo=%b result=%h lat=%0d required 0/00000014/33", tmo2, res2, lat2);
        end
        n_tests++;
        if (t2 - t1 != 34) begin
            n_fail++;
            $display("FAIL b2b_spacing: done pulses %0d cycles apart required 34", t2 - t1);
        end
        @(negedge clk);
        md_start_ex = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded M-extension op and the post-forwarding rs1/rs2 operands. Runs a 32-iteration radix-2 shift-add multiply or restoring divide.
- Raises a stall request to the hazard unit until the result is ready; the result is muxed into the EX result path on done.

Parameters:
- XLEN, 32, operand/result width (equals `REG_DATA_WIDTH).
- ITER, 32, iterations per mul/div op; the counter width is clog2(ITER)+1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- md_start_ex  in  1  EX-stage instruction is an M-extension op
- md_op_ex  in  `MD_OP_WIDTH (3)  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- op_a  in  XLEN  rs1 operand after forwarding
- op_b  in  XLEN  rs2 operand after forwarding
- flush  in  1  branch/redirect kill of the EX instruction
- md_result  out  XLEN  final result, valid while md_done=1
- md_done  out  1  result valid this cycle (one-cycle pulse)
- md_busy  out  1  FSM not IDLE
- md_stall_req  out  1  hold IF/ID/ID-EX; the hazard unit encodes it as `STALL_MULDIV

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, md_result=0, md_done=0, md_busy=0, internal acc/quot/rem regs=0. md_stall_req is 0 while in reset.
- States: IDLE, CALC, DONE.
- IDLE → CALC when md_start_ex=1, flush=0, and no special case.
  - Latches the op and sign flags.
  - Latches the unsigned magnitudes: abs for signed operands; MULHSU takes abs of op_a only, op_b raw.
  - Clears the accumulator/remainder and sets counter=0.
- IDLE → DONE directly (special case, 1-cycle stall):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per cycle; counter increments.
  - MUL: if multiplier LSB=1, add the multiplicand to the upper half of the 64-bit accumulator, then shift right 1.
  - DIV: shift the {rem,quot} pair left 1; if rem≥divisor, subtract and set the quotient LSB.
  - CALC → DONE after counter reaches ITER-1, so there are exactly ITER CALC cycles.
- DONE: md_done=1 for exactly one cycle, md_result registered → IDLE. md_start_ex is ignored in DONE.
- Sign fix, applied when entering DONE:
  - Product: negate the 64-bit value if the operand signs differ (MULHSU: op_a sign only).
  - Quotient: negate if the signs differ.
  - Remainder: takes the sign of the dividend.
  - Result select: MUL → product[31:0]; MULH/MULHSU/MULHU → product[63:32].
- md_stall_req (combinational) = (IDLE & md_start_ex & ~flush) | CALC. It is 0 in DONE, so the pipeline advances on the done cycle.
- Latency, start cycle to md_done: normal = ITER+1 cycles (33); special case = 1 cycle. Stall asserted for 33 and 1 cycles respectively.
- Back-to-back ops: the next M op enters EX the cycle after DONE, finds IDLE and starts normally. There are no dead cycles beyond DONE.
- flush in CALC: abort to IDLE next edge; no md_done; stall drops the same cycle flush is seen (combinational term masked).
- flush in IDLE with md_start_ex: no start. flush in DONE: md_done still pulses; the downstream pipeline register discards it.
- Reset mid-operation: immediate return to IDLE; no md_done.
- All arithmetic is unsigned 64/33-bit internally; no X propagation from unselected ops.

Decomposition:
- Add to the shared defines: `MD_OP_WIDTH, the eight `MD_* op codes, and `STALL_MULDIV (a new stall code alongside `STALL_LOAD/`STALL_BRANCH).
- Keep a state enum (md_state_t) in the same shared file.
- Natural sub-module: ex_div_core, the restoring-divide datapath (step logic only). The FSM, counter, multiplier and sign fix stay in ex_muldiv_unit.

Test Plan:
- MUL op_a=7, op_b=-3 (0xFFFFFFFD) → stall 33 cycles, md_done pulse, md_result=0xFFFFFFEB. MULH same operands → 0xFFFFFFFF.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU op_a=-1, op_b=2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5, DIV 0x80000000/-1 → 0x80000000, REM → 0; each completes with a 1-cycle stall.
- Start DIVU, assert flush at CALC cycle 10 → IDLE next cycle, md_done never asserted, md_stall_req=0. Then a new MUL 3×4 → 12 after 33 cycles.
- Drive rst=0 asynchronously mid-CALC → outputs 0 immediately. Then two back-to-back MULs (2×3, 4×5) → results 6 then 20, done pulses 34 cycles apart.
